// File: rtl/sha_msg_tx.sv
// sha_msg_tx: gathers big-endian host message words into 16-word SHA-256
// blocks, applies the 0x80 marker / zero fill / 64-bit bit-length padding,
// and streams each block to the message expander one word per cycle.
module sha_msg_tx #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_valid_in,
    output logic                  msg_ready_out,
    input  logic [DATA_WIDTH-1:0] msg_data_in,
    input  logic                  msg_last_in,
    input  logic [2:0]            msg_bytes_in,
    output logic                  start_out,
    output logic [4:0]            Tx_core_count,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  me_done_in,
    output logic                  block_last_out,
    output logic [2:0]            o_FSM_state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] MARK_WORD = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PAD     = 3'd2,
        SEND    = 3'd3,
        WAIT_ME = 3'd4,
        PAD2    = 3'd5
    } state_t;

    state_t state;
    state_t state_d;

    // Block buffer and message bookkeeping
    logic [DATA_WIDTH-1:0] buffer [16];
    logic [4:0]            wr_idx;       // next buffer slot to fill; may run past 15
    logic [63:0]           bit_len;      // running message length in bits
    logic                  block_final;  // block being sent carries the length
    logic                  ovf_pending;  // length did not fit, an extra block follows
    logic                  marker_next;  // 0x80 marker belongs in word 0 of the extra block
    logic                  len_fits;     // marker landed at index 13 or below

    // Registered expander-side outputs
    logic                  start_q;
    logic [4:0]            cnt_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Handshake-side decode
    logic                  hs;
    logic [4:0]            base_idx;
    logic [63:0]           base_len;
    logic [3:0]            n_bytes;
    logic                  full_last;
    logic [DATA_WIDTH-1:0] last_word;
    logic [4:0]            marker_pos;
    logic [DATA_WIDTH-1:0] first_word;

    assign msg_ready_out = (state == IDLE) || (state == LOAD);
    assign hs            = msg_valid_in && msg_ready_out;

    // A message starting from IDLE begins from an empty block and zero length.
    assign base_idx = (state == IDLE) ? 5'd0  : wr_idx;
    assign base_len = (state == IDLE) ? 64'd0 : bit_len;

    // Trim and mark the final word; locate the 0x80 marker.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        n_bytes   = 4'(BYTES);
        last_word = '0;
        if (msg_bytes_in != 3'd0 && {1'b0, msg_bytes_in} < 4'(BYTES)) begin
            n_bytes = {1'b0, msg_bytes_in};
        end
        full_last = (n_bytes == 4'(BYTES));
        for (int k = 0; k < BYTES; k++) begin
            if (k < int'(n_bytes)) begin
                last_word[DATA_WIDTH-1-8*k -: 8] = msg_data_in[DATA_WIDTH-1-8*k -: 8];
            end else if (k == int'(n_bytes)) begin
                last_word[DATA_WIDTH-1-8*k -: 8] = 8'h80;
            end
        end
        marker_pos = base_idx + (full_last ? 5'd1 : 5'd0);
    end

    // Word 0 of a block: the extra length block builds it in the same cycle it is sent.
    assign first_word = (state == PAD2) ? (marker_next ? MARK_WORD : '0) : buffer[0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
            state <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state;
        case (state)
            IDLE, LOAD: begin
                if (hs) begin
                    if (msg_last_in) begin
                        state_d = PAD;
                    end else if (base_idx == 5'd15) begin
                        state_d = SEND;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            PAD: begin
                if (len_fits ? (wr_idx == 5'd14) : wr_idx[4]) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cnt_q == 5'd15) begin
                    state_d = WAIT_ME;
                end
            end
            WAIT_ME: begin
                if (me_done_in) begin
                    if (ovf_pending) begin
                        state_d = PAD2;
                    end else if (block_final) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            PAD2:    state_d = SEND;
            default: state_d = IDLE;
        endcase
    end

    // Buffer fill, padding and length bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the block buffer is reset on purpose so a new message never sees a stale block.
            for (int i = 0; i < 16; i++) begin
                buffer[i] <= '0;
            end
            wr_idx      <= '0;
            bit_len     <= '0;
            block_final <= 1'b0;
            ovf_pending <= 1'b0;
            marker_next <= 1'b0;
            len_fits    <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (hs) begin
                        block_final <= 1'b0;
                        if (msg_last_in) begin
                            buffer[base_idx[3:0]] <= last_word;
                            if (full_last && base_idx != 5'd15) begin
                                buffer[4'(base_idx + 5'd1)] <= MARK_WORD;
                            end
                            bit_len     <= base_len + {57'd0, n_bytes, 3'd0};
                            wr_idx      <= marker_pos + 5'd1;
                            len_fits    <= (marker_pos <= 5'd13);
                            marker_next <= (marker_pos == 5'd16);
                        end else begin
                            buffer[base_idx[3:0]] <= msg_data_in;
                            bit_len <= base_len + 64'(DATA_WIDTH);
                            wr_idx  <= base_idx + 5'd1;
                        end
                    end
                end
                PAD: begin
                    if (len_fits) begin
                        if (wr_idx == 5'd14) begin
                            buffer[14]  <= DATA_WIDTH'(bit_len[63:32]);
                            buffer[15]  <= DATA_WIDTH'(bit_len[31:0]);
                            block_final <= 1'b1;
                            ovf_pending <= 1'b0;
                        end else begin
                            buffer[wr_idx[3:0]] <= '0;
                            wr_idx <= wr_idx + 5'd1;
                        end
                    end else if (wr_idx[4]) begin
                        block_final <= 1'b0;
                        ovf_pending <= 1'b1;
                    end else begin
                        buffer[wr_idx[3:0]] <= '0;
                        wr_idx <= wr_idx + 5'd1;
                    end
                end
                WAIT_ME: begin
                    if (me_done_in) begin
                        wr_idx <= '0;
                    end
                end
                PAD2: begin
                    for (int i = 0; i < 14; i++) begin
                        buffer[i] <= '0;
                    end
                    if (marker_next) begin
                        buffer[0] <= MARK_WORD;
                    end
                    buffer[14]  <= DATA_WIDTH'(bit_len[63:32]);
                    buffer[15]  <= DATA_WIDTH'(bit_len[31:0]);
                    block_final <= 1'b1;
                    ovf_pending <= 1'b0;
                    marker_next <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Expander outputs: strobe, index and word are loaded together on each SEND edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else if (state != SEND && state_d == SEND) begin
            start_q <= 1'b1;
            cnt_q   <= '0;
            data_q  <= first_word;
        end else if (state == SEND) begin
            if (cnt_q == 5'd15) begin
                start_q <= 1'b0;
                cnt_q   <= '0;
                data_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + 5'd1;
                data_q <= buffer[4'(cnt_q + 5'd1)];
            end
        end
    end

    assign start_out      = start_q;
    assign Tx_core_count  = cnt_q;
    assign data_out       = data_q;
    assign block_last_out = start_q && block_final;
    assign o_FSM_state    = state;

endmodule

// File: tb/tb_sha_msg_tx.sv
// tb_sha_msg_tx: randomized host traffic against a byte-level SHA-256
// padding model; every streamed block word is compared to the model.
module tb_sha_msg_tx;

    localparam int BUDGET = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid_in;
    logic        msg_ready_out;
    logic [31:0] msg_data_in;
    logic        msg_last_in;
    logic [2:0]  msg_bytes_in;
    logic        start_out;
    logic [4:0]  Tx_core_count;
    logic [31:0] data_out;
    logic        me_done_in;
    logic        block_last_out;
    logic [2:0]  o_FSM_state;

    sha_msg_tx #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .msg_valid_in   (msg_valid_in),
        .msg_ready_out  (msg_ready_out),
        .msg_data_in    (msg_data_in),
        .msg_last_in    (msg_last_in),
        .msg_bytes_in   (msg_bytes_in),
        .start_out      (start_out),
        .Tx_core_count  (Tx_core_count),
        .data_out       (data_out),
        .me_done_in     (me_done_in),
        .block_last_out (block_last_out),
        .o_FSM_state    (o_FSM_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] msg_words [$];
    logic [31:0] exp_words [$];
    bit          exp_final [$];
    logic [31:0] got [16];

    int         dir_n [10] = '{1, 13, 13, 14, 14, 15, 15, 16, 16, 17};
    logic [2:0] dir_b [10] = '{3'd3, 3'd4, 3'd0, 3'd4, 3'd2, 3'd1, 3'd4, 3'd4, 3'd1, 3'd0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic fill_random(input int n);
        msg_words.delete();
        for (int i = 0; i < n; i++) begin
            msg_words.push_back($urandom);
        end
    endtask

    // Reference: standard SHA-256 padding over the message as a byte stream.
    task automatic build_expected(input logic [2:0] last_bytes);
        logic [7:0]  bq [$];
        logic [63:0] bits;
        logic [31:0] wd;
        int          nb;
        int          nblk;
        int          p;
        int          k;
        nb = (last_bytes == 3'd0) ? 4 : int'(last_bytes);
        exp_words.delete();
        exp_final.delete();
        for (int i = 0; i < msg_words.size(); i++) begin
            wd = msg_words[i];
            k  = (i == msg_words.size() - 1) ? nb : 4;
            for (int j = 0; j < k; j++) begin
                bq.push_back(wd[31 - 8*j -: 8]);
            end
        end
        bits = 64'(bq.size()) * 64'd8;
        bq.push_back(8'h80);
        while (bq.size() % 64 != 56) begin
            bq.push_back(8'h00);
        end
        for (int j = 7; j >= 0; j--) begin
            bq.push_back(bits[8*j +: 8]);
        end
        nblk = bq.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            exp_final.push_back(b == nblk - 1);
            for (int w = 0; w < 16; w++) begin
                p = 64*b + 4*w;
                exp_words.push_back({bq[p], bq[p+1], bq[p+2], bq[p+3]});
            end
        end
    endtask

    task automatic feed(input logic [2:0] last_bytes, input int gap_max);
        int t;
        bit acc;
        for (int i = 0; i < msg_words.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                msg_valid_in = 1'b0;
                msg_data_in  = $urandom;
                msg_last_in  = 1'($urandom);
                @(posedge clk); #1;
            end
            msg_valid_in = 1'b1;
            msg_data_in  = msg_words[i];
            msg_last_in  = (i == msg_words.size() - 1);
            msg_bytes_in = msg_last_in ? last_bytes : 3'($urandom);
            t   = 0;
            acc = 1'b0;
            while (!acc && t < BUDGET) begin
                @(negedge clk);
                acc = msg_ready_out;
                @(posedge clk); #1;
                t++;
            end
            check("word_accepted", 64'(acc), 64'd1);
            if (!acc) break;
        end
        msg_valid_in = 1'b0;
        msg_last_in  = 1'b0;
    endtask

    task automatic collect(input int done_max, input int early, input int hold);
        int nblk;
        int t;
        bit fin;
        bit seen;
        nblk = exp_final.size();
        for (int b = 0; b < nblk; b++) begin
            fin = exp_final[b];
            t   = 0;
            @(negedge clk);
            while (start_out !== 1'b1 && t < BUDGET) begin
                @(negedge clk);
                t++;
            end
            check("block_start", 64'(start_out), 64'd1);
            if (start_out !== 1'b1) return;
            for (int k = 0; k < 16; k++) begin
                me_done_in = (k == early);
                got[k] = data_out;
                check("send_start", 64'(start_out), 64'd1);
                check("send_count", 64'(Tx_core_count), 64'(k));
                check("send_word", 64'(data_out), 64'(exp_words[16*b + k]));
                check("send_last", 64'(block_last_out), 64'(fin));
                @(negedge clk);
            end
            me_done_in = 1'b0;
            check("send_over", 64'(start_out), 64'd0);
            check("wait_state", 64'(o_FSM_state), 64'd4);
            check("wait_stall", 64'(msg_ready_out), 64'd0);
            if (hold > 0) begin
                seen = 1'b0;
                repeat (hold) begin
                    @(negedge clk);
                    seen = seen | start_out;
                end
                check("hold_no_resend", 64'(seen), 64'd0);
                check("hold_state", 64'(o_FSM_state), 64'd4);
                check("hold_stall", 64'(msg_ready_out), 64'd0);
            end
            repeat ($urandom_range(done_max, 0)) @(negedge clk);
            me_done_in = 1'b1;
            @(negedge clk);
            me_done_in = 1'b0;
            if (b == nblk - 1) begin
                check("idle_after", 64'(o_FSM_state), 64'd0);
                check("ready_after", 64'(msg_ready_out), 64'd1);
            end
        end
    endtask

    task automatic run_msg(input logic [2:0] last_bytes, input int gap_max, input int done_max,
                           input int early, input int hold);
        @(posedge clk); #1;
        build_expected(last_bytes);
        fork
            feed(last_bytes, gap_max);
            collect(done_max, early, hold);
        join
    endtask

    task automatic abc_block_checks();
        check("abc_w0", 64'(got[0]), 64'h61626380);
        for (int i = 1; i < 15; i++) begin
            check("abc_zero", 64'(got[i]), 64'd0);
        end
        check("abc_w15", 64'(got[15]), 64'h18);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        logic [2:0] nb;
        rst          = 1'b1;
        msg_valid_in = 1'b0;
        msg_data_in  = '0;
        msg_last_in  = 1'b0;
        msg_bytes_in = '0;
        me_done_in   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start", 64'(start_out), 64'd0);
        check("rst_count", 64'(Tx_core_count), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_last", 64'(block_last_out), 64'd0);
        check("rst_ready", 64'(msg_ready_out), 64'd1);
        check("rst_state", 64'(o_FSM_state), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_state", 64'(o_FSM_state), 64'd0);

        // "abc"
        msg_words.delete();
        msg_words.push_back(32'h61626300);
        run_msg(3'd3, 2, 3, -1, 0);
        abc_block_checks();

        // 14 full words: length spills into a second block
        fill_random(14);
        run_msg(3'd4, 1, 3, -1, 0);
        check("w14full_b2_w0", 64'(got[0]), 64'd0);
        check("w14full_b2_w15", 64'(got[15]), 64'h1C0);

        // 16 full words: marker and length both in the second block
        fill_random(16);
        run_msg(3'd4, 1, 3, -1, 0);
        check("w16full_b2_w0", 64'(got[0]), 64'h80000000);
        check("w16full_b2_w15", 64'(got[15]), 64'h200);

        // me_done during SEND must be ignored
        msg_words.delete();
        msg_words.push_back(32'h61626300);
        run_msg(3'd3, 0, 2, 3, 20);

        // Reset in SEND cycle 7
        @(posedge clk); #1;
        msg_words.delete();
        msg_words.push_back(32'h61626300);
        feed(3'd3, 0);
        t = 0;
        @(negedge clk);
        while (!(start_out === 1'b1 && Tx_core_count == 5'd7) && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        check("reach_cycle7", 64'(Tx_core_count), 64'd7);
        rst = 1'b1;
        #1;
        check("midrst_start", 64'(start_out), 64'd0);
        check("midrst_state", 64'(o_FSM_state), 64'd0);
        check("midrst_count", 64'(Tx_core_count), 64'd0);
        check("midrst_data", 64'(data_out), 64'd0);
        check("midrst_last", 64'(block_last_out), 64'd0);
        check("midrst_ready", 64'(msg_ready_out), 64'd1);
        @(negedge clk);
        check("midrst_next_start", 64'(start_out), 64'd0);
        check("midrst_next_state", 64'(o_FSM_state), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        msg_words.delete();
        msg_words.push_back(32'h61626300);
        run_msg(3'd3, 2, 3, -1, 0);
        abc_block_checks();

        // Boundary table around the index 13/14/15 marker positions
        for (int i = 0; i < 10; i++) begin
            fill_random(dir_n[i]);
            run_msg(dir_b[i], 2, 3, -1, 0);
        end

        // Random messages
        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(40, 1);
            nb = 3'($urandom_range(4, 0));
            fill_random(n);
            run_msg(nb, 3, 4, -1, 0);
        end

        // 21 words with random valid gaps; length word = 8 * bytes sent
        nb = 3'($urandom_range(4, 1));
        fill_random(21);
        run_msg(nb, 3, 4, -1, 0);
        check("len21_w15", 64'(got[15]), 64'(8 * (80 + int'(nb))));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha_msg_tx.md
SHA_MSG_TX -- requirements
Module: sha_msg_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of message and output data.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port msg_valid_in  input  1  host word valid.
REQ-005 SHALL have port msg_ready_out  output  1  block accepts host word this cycle.
REQ-006 SHALL have port msg_data_in  input  DATA_WIDTH  message word, big-endian; first byte in bits 31:24.
REQ-007 SHALL have port msg_last_in  input  1  final message word.
REQ-008 SHALL have port msg_bytes_in  input  3  valid bytes of the final word, 1..4, MSB-aligned; 0 is treated as 4; ignored when msg_last_in=0.
REQ-009 SHALL have port start_out  output  1  word transfer strobe to the expander.
REQ-010 SHALL have port Tx_core_count  output  5  index 0..15 of the word on data_out.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  padded block word.
REQ-012 SHALL have port me_done_in  input  1  expander finished the current block (one-cycle pulse).
REQ-013 SHALL have port block_last_out  output  1  high with start_out during the final block of a message.
REQ-014 SHALL have port o_FSM_state  output  3  current state encoding.

Function
REQ-015 SHALL implement states IDLE=0, LOAD=1, PAD=2, SEND=3, WAIT_ME=4, PAD2=5.
REQ-016 IDLE -> LOAD on msg_valid_in=1; word index and 64-bit bit-length counter cleared on entering LOAD.
REQ-017 msg_ready_out SHALL be 1 only in IDLE and LOAD; a handshake (valid&ready) stores the word in buffer[index] and increments the index.
REQ-018 Each non-last accepted word SHALL add 32 to the bit length; a last word SHALL add 8*msg_bytes_in; length wraps modulo 2^64.
REQ-019 When a non-last handshake fills index 15, SHALL go to SEND with a non-final block.
REQ-020 On a last word, bytes beyond msg_bytes_in SHALL be zeroed and 0x80 placed in the first invalid byte; if msg_bytes_in=4, 0x80000000 SHALL be written to the next index; then go to PAD.
REQ-021 PAD SHALL write one zero word per cycle up to index 13; if the 0x80 byte lies at index <=13, words 14/15 SHALL be length[63:32]/length[31:0] and the block is final.
REQ-022 If the 0x80 byte lies at index 14 or 15, PAD SHALL zero-fill to index 15, send a non-final block, then PAD2 SHALL build a block of 14 zero words plus the length words, marked final.
REQ-023 SEND SHALL last exactly 16 cycles; in SEND cycle k, start_out=1, Tx_core_count=k, data_out=buffer[k], all registered and changing together.
REQ-024 After SEND cycle 15, SHALL enter WAIT_ME with start_out=0; me_done_in outside WAIT_ME SHALL be ignored.
REQ-025 WAIT_ME on me_done_in=1: -> PAD2 if an overflow block is pending, else -> IDLE if the block was final, else -> LOAD with index reset to 0.
REQ-026 block_last_out SHALL equal start_out AND (current block final).
REQ-027 msg_valid_in in PAD, SEND, WAIT_ME, PAD2 SHALL be stalled (not accepted) with no data loss.

Reset
REQ-028 rst=1 at any time, including mid-SEND, SHALL immediately force IDLE, start_out=0, Tx_core_count=0, data_out=0, block_last_out=0, msg_ready_out=1, length=0, buffer cleared.
REQ-029 After rst deasserts, the first message SHALL be processed as if no prior message existed.

Verification
REQ-030 "abc": one word 0x61626300, last, bytes=3 -> single final block: w0=0x61626380, w1..w14=0, w15=0x00000018; block_last_out high all 16 SEND cycles.
REQ-031 14 full words, last with bytes=4 -> block1: 14 data words, w14=0x80000000, w15=0, non-final; after me_done_in, block2: w0..w13=0, w14=0, w15=0x000001C0, final.
REQ-032 16 full words, last on word 15 -> block1 data only, non-final; block2 w0=0x80000000, w15=0x00000200, final.
REQ-033 me_done_in pulsed during SEND and held low afterwards -> block stays in WAIT_ME, msg_ready_out=0, no second SEND.
REQ-034 rst asserted in SEND cycle 7 -> next cycle start_out=0, o_FSM_state=0; new "abc" message yields exactly the REQ-030 block.
REQ-035 msg_valid_in toggled randomly with last on word 20 -> all words appear in order, no duplicates, length word equals 8 * bytes sent.
